// File: rtl/pulse_event_extractor.sv
// -----------------------------------------------------------------------------
// pulse_event_extractor
//
// Purpose: watches one signed filter output stream and detects threshold
// crossings. For each pulse it records the peak amplitude, the timestamp of
// the peak, the above-threshold width and a pileup flag. A pileup is a second
// local rise after the pulse has started falling. The record goes out through
// a single-entry valid/ready output register. Events that arrive while that
// register is still occupied are dropped and counted.
//
// Optional feature: define PULSE_EVENT_BASELINE_SUB_EN to subtract a slowly
// tracking baseline (IIR, 1/16 step, updated only while idle). With it
// undefined, raw samples are used for every compare and for the peak.
//
// Ports:
//   clk             system clock, all state on rising edge
//   reset           synchronous, active-high reset
//   enable          arms detection of new pulses (running pulse completes)
//   input_data      signed filter sample, one per clock
//   threshold       signed detection threshold, quasi-static
//   event_ready     downstream accepts the presented event
//   event_valid     event record present
//   event_amplitude peak sample value
//   event_time      timestamp of the peak sample
//   event_width     above-threshold sample count, saturating
//   event_pileup    second local rise seen inside the pulse
//   lost_count      events dropped due to backpressure, saturating
// -----------------------------------------------------------------------------
module pulse_event_extractor #(
    parameter int DATA_WIDTH = 16,
    parameter int TIME_WIDTH = 32,
    parameter int HOLDOFF    = 8,
    parameter int MIN_WIDTH  = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         enable,
    input  logic signed [DATA_WIDTH-1:0] input_data,
    input  logic signed [DATA_WIDTH-1:0] threshold,
    input  logic                         event_ready,
    output logic                         event_valid,
    output logic signed [DATA_WIDTH-1:0] event_amplitude,
    output logic [TIME_WIDTH-1:0]        event_time,
    output logic [15:0]                  event_width,
    output logic                         event_pileup,
    output logic [15:0]                  lost_count
);

    localparam int HC_W = (HOLDOFF > 1) ? $clog2(HOLDOFF + 1) : 1;
    localparam logic [HC_W-1:0]       HOLD_LOAD = HC_W'(HOLDOFF);
    localparam logic [HC_W-1:0]       HOLD_ONE  = HC_W'(1);
    localparam logic [15:0]           MIN_W     = 16'(MIN_WIDTH);
    localparam logic [TIME_WIDTH-1:0] TS_ONE    = TIME_WIDTH'(1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ABOVE   = 2'd1,
        ST_HOLDOFF = 2'd2
    } state_t;

    state_t                        state_r;
    state_t                        state_nx_s;
    logic signed [DATA_WIDTH-1:0]  data_q_r;
    logic signed [DATA_WIDTH-1:0]  cur_s;
    logic signed [DATA_WIDTH-1:0]  peak_r;
    logic signed [DATA_WIDTH-1:0]  prev_r;
    logic [TIME_WIDTH-1:0]         ts_cnt_r;
    logic [TIME_WIDTH-1:0]         ts_q_r;
    logic [TIME_WIDTH-1:0]         peak_t_r;
    logic [15:0]                   width_r;
    logic                          falling_r;
    logic                          pileup_r;
    logic [HC_W-1:0]               hold_r;
    logic                          above_s;
    logic                          start_s;
    logic                          cont_s;
    logic                          end_s;
    logic                          emit_s;

    // Input stage: register the sample with the timestamp of its arrival edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_q_r <= '0;
            ts_q_r   <= '0;
            ts_cnt_r <= '0;
        end else begin
            data_q_r <= input_data;
            ts_q_r   <= ts_cnt_r;
            ts_cnt_r <= ts_cnt_r + TS_ONE;
        end
    end

`ifdef PULSE_EVENT_BASELINE_SUB_EN
    // Baseline is held with 4 fractional bits so the 1/16 step does not stall.
    localparam int BL_W = DATA_WIDTH + 4;

    logic signed [BL_W-1:0]     baseline_r;
    logic signed [BL_W:0]       bl_diff_s;
    logic signed [BL_W:0]       bl_step_s;
    logic signed [DATA_WIDTH:0] corr_wide_s;

    function automatic logic signed [DATA_WIDTH-1:0] sat_data(input logic signed [DATA_WIDTH:0] v);
        if (v[DATA_WIDTH] != v[DATA_WIDTH-1]) begin
            sat_data = v[DATA_WIDTH] ? {1'b1, {(DATA_WIDTH-1){1'b0}}} : {1'b0, {(DATA_WIDTH-1){1'b1}}};
        end else begin
            sat_data = v[DATA_WIDTH-1:0];
        end
    endfunction

    // Baseline step and baseline-corrected sample.
    always_comb begin
        bl_diff_s   = $signed({data_q_r[DATA_WIDTH-1], data_q_r, 4'b0000})
                    - $signed({baseline_r[BL_W-1], baseline_r});
        bl_step_s   = bl_diff_s >>> 4;
        corr_wide_s = $signed({data_q_r[DATA_WIDTH-1], data_q_r})
                    - $signed({baseline_r[BL_W-1], baseline_r[BL_W-1:4]});
        cur_s       = sat_data(corr_wide_s);
    end

    // Baseline tracks only between pulses so a pulse cannot pull it upward.
    always_ff @(posedge clk) begin
        if (reset) begin
            baseline_r <= '0;
        end else if (state_r == ST_IDLE) begin
            baseline_r <= baseline_r + bl_step_s[BL_W-1:0];
        end else begin
            baseline_r <= baseline_r;
        end
    end
`else
    // Raw samples feed the detector directly.
    always_comb begin
        cur_s = data_q_r;
    end
`endif

    // Signed strict threshold compare.
    always_comb begin
        above_s = (cur_s > threshold);
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (enable && above_s) state_nx_s = ST_ABOVE;
                else                   state_nx_s = ST_IDLE;
            end
            ST_ABOVE: begin
                if (above_s) state_nx_s = ST_ABOVE;
                else         state_nx_s = ST_HOLDOFF;
            end
            ST_HOLDOFF: begin
                if (hold_r <= HOLD_ONE) state_nx_s = ST_IDLE;
                else                    state_nx_s = ST_HOLDOFF;
            end
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // FSM outputs: pulse start, continuation, end, and qualified emit.
    always_comb begin
        start_s = 1'b0;
        cont_s  = 1'b0;
        end_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                start_s = enable && above_s;
            end
            ST_ABOVE: begin
                cont_s = above_s;
                end_s  = !above_s;
            end
            ST_HOLDOFF: begin
                start_s = 1'b0;
            end
            default: begin
                start_s = 1'b0;
            end
        endcase
        emit_s = end_s && (width_r >= MIN_W);
    end

    // Pulse tracker: peak (first maximum wins), width, falling and pileup flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            peak_r    <= '0;
            peak_t_r  <= '0;
            prev_r    <= '0;
            width_r   <= 16'd0;
            falling_r <= 1'b0;
            pileup_r  <= 1'b0;
        end else if (start_s) begin
            peak_r    <= cur_s;
            peak_t_r  <= ts_q_r;
            prev_r    <= cur_s;
            width_r   <= 16'd1;
            falling_r <= 1'b0;
            pileup_r  <= 1'b0;
        end else if (cont_s) begin
            if (width_r != 16'hFFFF) width_r <= width_r + 16'd1;
            if (cur_s > peak_r) begin
                peak_r   <= cur_s;
                peak_t_r <= ts_q_r;
            end
            falling_r <= falling_r | (cur_s < prev_r);
            pileup_r  <= pileup_r | (falling_r && (cur_s > prev_r));
            prev_r    <= cur_s;
        end
    end

    // Holdoff counter: loaded at pulse end, counts down while in HOLDOFF.
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_r <= '0;
        end else if (end_s) begin
            hold_r <= HOLD_LOAD;
        end else if ((state_r == ST_HOLDOFF) && (hold_r != '0)) begin
            hold_r <= hold_r - HOLD_ONE;
        end
    end

    // Single-entry output register. A handshake in the same cycle frees the
    // slot for a new event; otherwise a new event is dropped and counted.
    always_ff @(posedge clk) begin
        if (reset) begin
            event_valid     <= 1'b0;
            event_amplitude <= '0;
            event_time      <= '0;
            event_width     <= 16'd0;
            event_pileup    <= 1'b0;
            lost_count      <= 16'd0;
        end else if (emit_s && (!event_valid || event_ready)) begin
            event_valid     <= 1'b1;
            event_amplitude <= peak_r;
            event_time      <= peak_t_r;
            event_width     <= width_r;
            event_pileup    <= pileup_r;
        end else if (emit_s) begin
            if (lost_count != 16'hFFFF) lost_count <= lost_count + 16'd1;
        end else if (event_valid && event_ready) begin
            event_valid <= 1'b0;
        end
    end

endmodule
